// File: rtl/mult_ctrl.sv
// mult_ctrl: sequencer around the shared WIDTH x WIDTH multiplier of the
// execute stage. Takes one request at a time over a valid/ready channel,
// drives registered operands into the multiplier, waits its fixed latency,
// then returns the product split into HI/LO with the request tag.
// Requests with a zero operand skip the multiplier wait.
module mult_ctrl #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2,
    parameter int TAG_W = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Req_Valid,
    output logic                 Req_Ready,
    input  logic [WIDTH-1:0]     Req_OpA,
    input  logic [WIDTH-1:0]     Req_OpB,
    input  logic [TAG_W-1:0]     Req_Tag,
    output logic [WIDTH-1:0]     Mult_OpA,
    output logic [WIDTH-1:0]     Mult_OpB,
    input  logic [2*WIDTH-1:0]   Mult_Result,
    output logic                 Rsp_Valid,
    input  logic                 Rsp_Ready,
    output logic [WIDTH-1:0]     Rsp_Hi,
    output logic [WIDTH-1:0]     Rsp_Lo,
    output logic [TAG_W-1:0]     Rsp_Tag,
    output logic                 Busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter is 4 bits wide, enough for the full 1..15 latency range.
    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] rsp_hi_q, rsp_hi_d;
    logic [WIDTH-1:0] rsp_lo_q, rsp_lo_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic             req_ready;
    logic             accept;
    logic             rsp_fire;
    logic             req_zero;

    // Ready is combinational in DONE so a new request can issue on the
    // same edge the pending response retires; held low throughout reset.
    always_comb begin
        req_ready = 1'b0;
        case (state_q)
            S_IDLE:  req_ready = 1'b1;
            S_DONE:  req_ready = Rsp_Ready;
            default: req_ready = 1'b0;
        endcase
        if (Rst) begin
            req_ready = 1'b0;
        end
    end

    assign accept   = Req_Valid & req_ready;
    assign rsp_fire = rsp_valid_q & Rsp_Ready;
    assign req_zero = (Req_OpA == '0) || (Req_OpB == '0);

    // Next-state logic: IDLE/DONE share the accept path, RUN counts down
    // the multiplier latency and captures the product when it expires.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        tag_d       = tag_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Retire the current response first; an accept below may
                // immediately reload it via the zero shortcut.
                if (state_q == S_DONE && rsp_fire) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
                if (accept) begin
                    opa_d = Req_OpA;
                    opb_d = Req_OpB;
                    tag_d = Req_Tag;
                    if (req_zero) begin
                        rsp_hi_d    = '0;
                        rsp_lo_d    = '0;
                        rsp_tag_d   = Req_Tag;
                        rsp_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == 4'd0) begin
                    rsp_hi_d    = Mult_Result[2*WIDTH-1:WIDTH];
                    rsp_lo_d    = Mult_Result[WIDTH-1:0];
                    rsp_tag_d   = tag_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            opa_q       <= '0;
            opb_q       <= '0;
            tag_q       <= '0;
            rsp_hi_q    <= '0;
            rsp_lo_q    <= '0;
            rsp_tag_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            tag_q       <= tag_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign Req_Ready = req_ready;
    assign Mult_OpA  = opa_q;
    assign Mult_OpB  = opb_q;
    assign Rsp_Valid = rsp_valid_q;
    assign Rsp_Hi    = rsp_hi_q;
    assign Rsp_Lo    = rsp_lo_q;
    assign Rsp_Tag   = rsp_tag_q;
    assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed testbench for mult_ctrl with a behavioural multiplier whose
// product settles within LAT=2 cycles of an operand change.
module tb_mult_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_opa;
    logic [15:0] req_opb;
    logic [3:0]  req_tag;
    logic [15:0] mult_opa;
    logic [15:0] mult_opb;
    logic [31:0] mult_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_hi;
    logic [15:0] rsp_lo;
    logic [3:0]  rsp_tag;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mult_ctrl #(.WIDTH(16), .LAT(2), .TAG_W(4)) dut (
        .Clk         (clk),
        .Rst         (rst),
        .Req_Valid   (req_valid),
        .Req_Ready   (req_ready),
        .Req_OpA     (req_opa),
        .Req_OpB     (req_opb),
        .Req_Tag     (req_tag),
        .Mult_OpA    (mult_opa),
        .Mult_OpB    (mult_opb),
        .Mult_Result (mult_result),
        .Rsp_Valid   (rsp_valid),
        .Rsp_Ready   (rsp_ready),
        .Rsp_Hi      (rsp_hi),
        .Rsp_Lo      (rsp_lo),
        .Rsp_Tag     (rsp_tag),
        .Busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: product registered once after the operands
    // change, so it is stable before the second edge after the change.
    always @(posedge clk) mult_result <= 32'(mult_opa) * 32'(mult_opb);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({mult_opa, mult_opb, rsp_hi, rsp_lo, rsp_tag} !== 68'd0) begin errors++; $display("FAIL reset_data: got %h %h %h %h %h want all 0", mult_opa, mult_opb, rsp_hi, rsp_lo, rsp_tag); end
        #10;
        rst = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_basic(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                              input logic [15:0] ehi, input logic [15:0] elo);
        int busy_cnt;
        busy_cnt  = 0;
        req_valid = 1'b1;
        req_opa   = a;
        req_opb   = b;
        req_tag   = tag;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        if (busy) busy_cnt++;
        checks++; if (mult_opa !== a || mult_opb !== b) begin errors++; $display("FAIL basic_ops: got %h %h want %h %h", mult_opa, mult_opb, a, b); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_early1: rsp_valid got %b want 0", rsp_valid); end
        tick();
        if (busy) busy_cnt++;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_early2: rsp_valid got %b want 0", rsp_valid); end
        tick();
        if (busy) busy_cnt++;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_hi !== ehi || rsp_lo !== elo) begin errors++; $display("FAIL basic_product: got %h_%h want %h_%h", rsp_hi, rsp_lo, ehi, elo); end
        checks++; if (rsp_tag !== tag) begin errors++; $display("FAIL basic_tag: got %h want %h", rsp_tag, tag); end
        tick();
        if (busy) busy_cnt++;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_retire: rsp_valid got %b want 0", rsp_valid); end
        checks++; if (busy_cnt != 3) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 3", busy_cnt); end
    endtask

    task automatic test_zero();
        req_valid = 1'b1;
        req_opa   = 16'h0000;
        req_opb   = 16'h1234;
        req_tag   = 4'd1;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_hi !== 16'h0 || rsp_lo !== 16'h0) begin errors++; $display("FAIL zero_product: got %h_%h want 0000_0000", rsp_hi, rsp_lo); end
        checks++; if (rsp_tag !== 4'd1) begin errors++; $display("FAIL zero_tag: got %h want 1", rsp_tag); end
        checks++; if (mult_opb !== 16'h1234) begin errors++; $display("FAIL zero_ops: got %h want 1234", mult_opb); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_retire: valid %b busy %b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1;
        req_opa   = 16'd3;
        req_opb   = 16'd4;
        req_tag   = 4'd2;
        rsp_ready = 1'b0;
        tick();
        // A competing request while not ready must be ignored.
        req_opa = 16'd9;
        req_opb = 16'd9;
        req_tag = 4'd9;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_run: got %b want 0", req_ready); end
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_lo !== 16'h000C || rsp_hi !== 16'h0 || rsp_tag !== 4'd2) begin
                errors++; $display("FAIL bp_hold[%0d]: valid %b prod %h_%h tag %h want 1 0000_000c 2", i, rsp_valid, rsp_hi, rsp_lo, rsp_tag);
            end
            checks++; if (req_ready !== 1'b0 || mult_opa !== 16'd3) begin errors++; $display("FAIL bp_ready[%0d]: ready %b opa %h want 0 0003", i, req_ready, mult_opa); end
            if (i < 4) tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_retire: valid %b busy %b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_opa   = 16'd2;
        req_opb   = 16'd3;
        req_tag   = 4'd4;
        tick();
        req_opa = 16'd5;
        req_opb = 16'd7;
        req_tag = 4'd5;
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_lo !== 16'h0006 || rsp_tag !== 4'd4) begin errors++; $display("FAIL b2b_first: valid %b lo %h tag %h want 1 0006 4", rsp_valid, rsp_lo, rsp_tag); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_done: got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || mult_opa !== 16'd5) begin errors++; $display("FAIL b2b_reissue: valid %b busy %b opa %h want 0 1 0005", rsp_valid, busy, mult_opa); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_early: got %b want 0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_lo !== 16'h0023 || rsp_tag !== 4'd5) begin errors++; $display("FAIL b2b_second: valid %b lo %h tag %h want 1 0023 5", rsp_valid, rsp_lo, rsp_tag); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy %b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        int seen;
        seen      = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_opa   = 16'd100;
        req_opb   = 16'd100;
        req_tag   = 4'd6;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if ({rsp_valid, req_ready, busy} !== 3'b000) begin errors++; $display("FAIL abort_ctrl: valid %b ready %b busy %b want 000", rsp_valid, req_ready, busy); end
        checks++; if ({mult_opa, mult_opb, rsp_hi, rsp_lo, rsp_tag} !== 68'd0) begin errors++; $display("FAIL abort_data: %h %h %h %h %h want all 0", mult_opa, mult_opb, rsp_hi, rsp_lo, rsp_tag); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        checks++; if (seen != 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_rsp: valid cycles %0d busy %b want 0 0", seen, busy); end
        test_basic(16'd2, 16'd2, 4'd8, 16'h0000, 16'h0004);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_opa   = '0;
        req_opb   = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_basic(16'd10, 16'd50, 4'd3, 16'h0000, 16'h01F4);
        test_basic(16'hFFFF, 16'hFFFF, 4'd7, 16'hFFFE, 16'h0001);
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- Sequencer wrapping the shared 16x16 multiplier (`Mult`: OpA/OpB in, 32-bit Result out) for the MIPS execute stage.
- Accepts one multiply request at a time over a valid/ready handshake and drives registered operands into the multiplier.
- Waits the multiplier's fixed latency, then captures the product split into HI/LO halves with its destination tag.
- Presents the result on a valid/ready response channel. Operands of zero bypass the multiplier wait.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH
LAT, 2, multiplier latency in cycles from operand change to stable Mult_Result; legal range 1..15
TAG_W, 4, width of request/response tag

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-high
Req_Valid  in  1  request present
Req_Ready  out  1  controller can accept request this cycle
Req_OpA  in  WIDTH  operand A
Req_OpB  in  WIDTH  operand B
Req_Tag  in  TAG_W  destination tag, returned with result
Mult_OpA  out  WIDTH  registered operand A to multiplier
Mult_OpB  out  WIDTH  registered operand B to multiplier
Mult_Result  in  2*WIDTH  multiplier product
Rsp_Valid  out  1  result present
Rsp_Ready  in  1  consumer takes result this cycle
Rsp_Hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]
Rsp_Lo  out  WIDTH  product bits [WIDTH-1:0]
Rsp_Tag  out  TAG_W  tag of this result
Busy  out  1  state != IDLE

Behaviour:
Reset (Rst high, async):
- State goes to IDLE.
- All registered outputs are 0: Mult_OpA, Mult_OpB, Rsp_Hi, Rsp_Lo, Rsp_Tag, Rsp_Valid, Busy.
- Counter is 0. Req_Ready=0 while Rst is asserted.

FSM states IDLE, RUN, DONE.

IDLE:
- Req_Ready=1.
- Accept on Req_Valid&Req_Ready at edge N: Mult_OpA/OpB<=Req_OpA/OpB, tag<=Req_Tag.
- If either operand is 0: Rsp_Hi/Rsp_Lo<=0, Rsp_Tag<=Req_Tag, Rsp_Valid<=1, go DONE. Response is visible after edge N.
- Otherwise: cnt<=LAT-1, go RUN.

RUN:
- Req_Ready=0.
- If cnt==0: capture Rsp_Hi/Rsp_Lo<=Mult_Result halves, Rsp_Tag<=tag, Rsp_Valid<=1, go DONE.
- Else cnt<=cnt-1.
- Net: accept at edge N means Mult_Result is sampled at edge N+LAT and Rsp_Valid is high after edge N+LAT.

DONE:
- Rsp_Valid=1. Rsp_Hi/Lo/Tag are held stable until the handshake.
- Req_Ready = Rsp_Ready. This is a combinational path, so back-to-back issue is allowed.
- Rsp_Valid&Rsp_Ready with no new request: Rsp_Valid<=0, go IDLE.
- Response and request handshakes on the same edge: retire the old response and accept the new request with IDLE accept rules, going to RUN or DONE. Rsp_Valid stays 1 only if the zero shortcut reloads it, otherwise it drops to 0.

Operand and data rules:
- Mult_OpA/OpB change only on an accept edge and are held otherwise, including during DONE and IDLE.
- No arithmetic in this block: the product is passed through bit-exact.

Boundary conditions:
- Req_Valid high while Req_Ready is low: ignored. The request must be held by the requester.
- Rsp_Ready high while Rsp_Valid is low: no effect.
- Rst mid-RUN or mid-DONE: operation is aborted, no response is issued, state is IDLE next cycle after deassert.
- LAT=1: RUN lasts exactly one cycle.

Test Plan:
(Bench pairs the controller with a behavioural `Mult` model delaying the product by LAT=2; WIDTH=16.)
- Rst high 22ns then low, Req OpA=10 OpB=50 Tag=3, Rsp_Ready=1 -> Rsp_Valid high 2 cycles after accept edge; Rsp_Hi=0x0000, Rsp_Lo=0x01F4, Rsp_Tag=3; Busy high for 3 cycles.
- OpA=0xFFFF OpB=0xFFFF Tag=7 -> Rsp_Hi=0xFFFE, Rsp_Lo=0x0001, Rsp_Tag=7.
- Zero shortcut: OpA=0 OpB=0x1234 Tag=1 -> Rsp_Valid the cycle after accept, Hi=Lo=0, no RUN state.
- Backpressure: product 3*4 with Rsp_Ready=0 for 5 cycles -> Rsp_Valid, Lo=0x000C and Tag held stable; Req_Ready=0 throughout; retires on first Rsp_Ready=1.
- Back-to-back: Rsp_Ready=1, Req_Valid held with 2*3 then 5*7 -> second accept on the same edge the first response retires; responses Lo=0x0006 then Lo=0x0023, in order, no gap state.
- Rst pulse 1 cycle after accept of 100*100 -> all outputs 0 during reset, no response ever appears for that request; next request 2*2 yields Lo=0x0004.
